// File: rtl/coin_pkg.sv
// Coin encoder shared definitions.
// Coin codes, FSM states and widths.
package coin_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  localparam int DEB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/coin_debounce.sv
// Per-sensor debouncer: one event per qualified high period.
// Disarmed after reset until a low sample is seen.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEB_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic sense_i,
  output logic event_o
);

  localparam logic [DEB_W-1:0] SAT_C  = DEB_W'(DEB_CYCLES);
  localparam logic [DEB_W-1:0] LAST_C = DEB_W'(DEB_CYCLES - 1);

  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;

  // Count consecutive highs, saturate, re-arm on a low sample.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (!sense_i) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (armed_q && cnt_q != SAT_C) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign event_o = armed_q & sense_i & (cnt_q == LAST_C);

endmodule

// File: rtl/coin_encoder.sv
// Coin encoder: debounced sensors feed an event FIFO,
// drained one code at a time to the vending machine.
module coin_encoder
  import coin_pkg::*;
#(
  parameter int DEB_CYCLES = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sense_5,
  input  logic       sense_10,
  input  logic       vend_busy,
  output logic [1:0] coin_code,
  output logic       coin_reject,
  output logic       fifo_full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic ev5, ev10;
  logic both, one, push, pop, drop, empty;
  logic [1:0] push_code;

  logic [1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          reject_q;
  state_e        state_q;
  logic [1:0]    code_q;

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb5 (
    .clk     (clk),
    .rst     (rst),
    .sense_i (sense_5),
    .event_o (ev5)
  );

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb10 (
    .clk     (clk),
    .rst     (rst),
    .sense_i (sense_10),
    .event_o (ev10)
  );

  assign both      = ev5 & ev10;
  assign one       = ev5 ^ ev10;
  assign push_code = ev5 ? COIN_5 : COIN_10;
  assign empty     = (cnt_q == '0);
  assign fifo_full = (cnt_q == DEPTH_C);
  assign pop       = (state_q == IDLE) & ~empty & ~vend_busy;
  // A pop at the same edge frees a slot for the incoming event.
  assign push      = one & (~fifo_full | pop);
  assign drop      = one & fifo_full & ~pop;

  // FIFO storage; contents need no reset, pointers guard validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_code;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // One-cycle reject pulse for collisions and overflow.
  always_ff @(posedge clk) begin
    if (rst) reject_q <= 1'b0;
    else     reject_q <= both | drop;
  end

  // Output FSM: IDLE -> SEND (one code cycle) -> GAP -> IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= COIN_NONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= SEND;
            code_q  <= mem_q[rd_q];
          end else begin
            code_q  <= COIN_NONE;
          end
        end
        SEND: begin
          state_q <= GAP;
          code_q  <= COIN_NONE;
        end
        GAP: begin
          state_q <= IDLE;
          code_q  <= COIN_NONE;
        end
        default: begin
          state_q <= IDLE;
          code_q  <= COIN_NONE;
        end
      endcase
    end
  end

  assign coin_code   = code_q;
  assign coin_reject = reject_q;

endmodule

// File: tb/tb_coin_encoder.sv
// Directed bench for coin_encoder.
// Hand-computed expectations, one check task.
module tb_coin_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       sense_5;
  logic       sense_10;
  logic       vend_busy;
  logic [1:0] coin_code;
  logic       coin_reject;
  logic       fifo_full;

  int n_chk  = 0;
  int n_fail = 0;
  int n5, n10, n11, nrej, nback;
  logic [1:0] prev;

  coin_encoder #(.DEB_CYCLES(3), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .sense_5     (sense_5),
    .sense_10    (sense_10),
    .vend_busy   (vend_busy),
    .coin_code   (coin_code),
    .coin_reject (coin_reject),
    .fifo_full   (fifo_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n5 = 0; n10 = 0; n11 = 0; nrej = 0; nback = 0;
    prev = 2'b00;
  endtask

  // Advance one edge, sample 1 time unit later, tally outputs.
  task automatic tick();
    @(posedge clk);
    #1;
    if (coin_code == 2'b01) n5++;
    if (coin_code == 2'b10) n10++;
    if (coin_code == 2'b11) n11++;
    if (coin_code != 2'b00 && prev != 2'b00) nback++;
    if (coin_reject) nrej++;
    prev = coin_code;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; sense_5 = 1'b0; sense_10 = 1'b0; vend_busy = 1'b0;
    clr();
    ticks(2);
    check("rst_code", coin_code, 0);
    check("rst_rej", coin_reject, 0);
    check("rst_full", fifo_full, 0);

    // Single 5 coin: enqueue at edge 3, code after edge 4.
    rst = 1'b0;
    tick();
    sense_5 = 1'b1;
    tick();
    check("c5_e1", coin_code, 0);
    ticks(2);
    check("c5_e3", coin_code, 0);
    tick();
    check("c5_e4", coin_code, 1);
    sense_5 = 1'b0;
    tick();
    check("c5_e5", coin_code, 0);
    tick();
    check("c5_e6", coin_code, 0);
    ticks(3);

    // Long 10 press yields exactly one event.
    clr();
    sense_10 = 1'b1;
    ticks(20);
    sense_10 = 1'b0;
    ticks(3);
    check("long10_n", n10, 1);
    sense_10 = 1'b1;
    ticks(3);
    sense_10 = 1'b0;
    ticks(4);
    check("rearm10_n", n10, 2);
    check("long_n5", n5, 0);

    // Simultaneous events are rejected.
    clr();
    sense_5 = 1'b1; sense_10 = 1'b1;
    ticks(2);
    check("both_e2_rej", coin_reject, 0);
    tick();
    check("both_e3_rej", coin_reject, 1);
    tick();
    check("both_e4_rej", coin_reject, 0);
    sense_5 = 1'b0; sense_10 = 1'b0;
    ticks(5);
    check("both_nrej", nrej, 1);
    check("both_codes", n5 + n10, 0);

    // Overflow with vend_busy, then drain four codes.
    clr();
    vend_busy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      sense_5 = 1'b1;
      ticks(3);
      if (c == 2) check("ovf_full3", fifo_full, 0);
      if (c == 3) check("ovf_full4", fifo_full, 1);
      if (c == 4) check("ovf_rej5", coin_reject, 1);
      sense_5 = 1'b0;
      tick();
    end
    check("ovf_nrej", nrej, 1);
    check("ovf_busy_codes", n5, 0);
    vend_busy = 1'b0;
    tick();
    check("drain_first", coin_code, 1);
    check("drain_notfull", fifo_full, 0);
    ticks(14);
    check("drain_n5", n5, 4);
    check("drain_back", nback, 0);

    // Reset during SEND drops the pending events.
    clr();
    vend_busy = 1'b1;
    for (int c = 0; c < 2; c++) begin
      sense_5 = 1'b1;
      ticks(3);
      sense_5 = 1'b0;
      tick();
    end
    vend_busy = 1'b0;
    tick();
    check("rs_send", coin_code, 1);
    rst = 1'b1;
    tick();
    check("rs_code", coin_code, 0);
    check("rs_full", fifo_full, 0);
    rst = 1'b0;
    clr();
    ticks(10);
    check("rs_nocodes", n5 + n10, 0);

    // Sensor high through reset release must wait for a low.
    clr();
    sense_5 = 1'b1;
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    ticks(6);
    check("hold_nocode", n5, 0);
    sense_5 = 1'b0;
    tick();
    sense_5 = 1'b1;
    ticks(3);
    tick();
    check("hold_code", coin_code, 1);
    sense_5 = 1'b0;
    ticks(3);
    check("hold_n5", n5, 1);
    check("never11", n11, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
